// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: one full_subtractor slice, LSB first, start/done handshake.
// Define SERIAL_SUB_CLAMP_EN for unsigned saturation (diff forced to 0 on final borrow).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic difference,
    output logic borrow
);
    assign difference = a ^ b ^ c;
    assign borrow     = (~a & b) | (~(a ^ b) & c);
endmodule

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:1] res_sr;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             s_d;
    logic             s_b;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] fin;

    full_subtractor u_slice (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .c          (brw),
        .difference (s_d),
        .borrow     (s_b)
    );

    assign res_nxt = {s_d, res_sr[WIDTH-1:1]};

`ifdef SERIAL_SUB_CLAMP_EN
    assign fin = s_b ? '0 : res_nxt;
`else
    assign fin = res_nxt;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_sr <= res_nxt[WIDTH-1:1];
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    brw    <= s_b;
                    cnt    <= cnt + CW'(1);
                    // final slice result lands directly in the output registers
                    if (cnt == LAST) begin
                        state <= DONE;
                        diff  <= fin;
                        bout  <= s_b;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Bench for serial_subtract_ctrl: timeline model plus directed literal checks.
// Build with SERIAL_SUB_CLAMP_EN to check saturating expectations.
module tb_serial_subtract_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    serial_subtract_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // model: phase = cycles since accept (0 = idle)
    int           phase = 0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    logic         mbin = 1'b0;
    logic [W-1:0] ediff = '0;
    logic         ebout = 1'b0;
    int           full;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0;
            ediff = '0;
            ebout = 1'b0;
        end else if (phase == 0) begin
            if (start === 1'b1) begin
                ma = a;
                mb = b;
                mbin = bin;
                phase = 1;
            end
        end else if (phase == W + 1) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == W + 1) begin
                full  = int'(ma) - int'(mb) - int'(mbin);
                ebout = (full < 0);
                ediff = W'(full + (1 << W));
`ifdef SERIAL_SUB_CLAMP_EN
                if (ebout) ediff = '0;
`endif
            end
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("done", 32'(done), 32'(phase == W + 1));
        chk("diff", 32'(diff), 32'(ediff));
        chk("bout", 32'(bout), 32'(ebout));
    end

    task automatic run_op(string n, logic [W-1:0] ia, logic [W-1:0] ib,
                          logic ic, logic [W-1:0] xd, logic xb);
        int nb;
        int dc;
        @(negedge clk);
        a = ia; b = ib; bin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib; bin = ~ic;
        nb = 0; dc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!busy) break;
            nb++;
            if (done) begin
                dc = i;
                chk({n, "_diff"}, 32'(diff), 32'(xd));
                chk({n, "_bout"}, 32'(bout), 32'(xb));
            end
            @(negedge clk);
        end
        chk({n, "_busycyc"}, 32'(nb), 32'(W + 1));
        chk({n, "_donecyc"}, 32'(dc), 32'(W + 1));
    endtask

    task automatic wait_done(string n, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) return;
        end
        chk({n, "_timeout"}, 32'(0), 32'(1));
    endtask

`ifdef SERIAL_SUB_CLAMP_EN
    localparam logic [W-1:0] D2 = 8'h00;
    localparam logic [W-1:0] D3 = 8'h00;
`else
    localparam logic [W-1:0] D2 = 8'hF0;
    localparam logic [W-1:0] D3 = 8'hFF;
`endif

    initial begin
        int c1;
        int c2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        rst = 1'b0;

        run_op("t1", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        run_op("t2", 8'h10, 8'h20, 1'b0, D2, 1'b1);
        run_op("t3a", 8'h00, 8'h00, 1'b1, D3, 1'b1);
        run_op("t3b", 8'hFF, 8'hFF, 1'b1, D3, 1'b1);

        // start pulses during RUN and DONE are ignored
        @(negedge clk);
        a = 8'hC3; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h99; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", c1);
        chk("t4_diff", 32'(diff), 32'(8'h87));
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_idle", 32'(busy), 32'(0));
        chk("t4_hold", 32'(diff), 32'(8'h87));

        // start held high: back-to-back accepts
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h01;
        wait_done("t5a", c1);
        chk("t5a_diff", 32'(diff), 32'(8'h7F));
        wait_done("t5b", c2);
        start = 1'b0;
        chk("t5_period", 32'(c2), 32'(W + 2));
        chk("t5b_diff", 32'(diff), 32'(8'h00));
        chk("t5b_bout", 32'(bout), 32'(0));
        repeat (3) @(negedge clk);

        // reset in the middle of RUN
        a = 8'hF0; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_done", 32'(done), 32'(0));
        chk("t6_diff", 32'(diff), 32'(0));
        chk("t6_bout", 32'(bout), 32'(0));
        #1 rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("t6_nodone", 32'(done), 32'(0));
        end
        run_op("t6", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
